// File: rtl/psram_pkg.sv
// Shared types and default widths for the PSRAM controller and its front end.
package psram_pkg;

   localparam int PSRAM_ADDRESS_BITS = 23;
   localparam int PSRAM_DATA_BITS    = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } arb_state_t;

   typedef logic client_id_t;

endpackage

// File: rtl/psram_rr_arbiter.sv
// Two-way round-robin grant; the registered pointer remembers the last client served.
module psram_rr_arbiter
   import psram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   client_id_t last;

   always_comb begin
      grant = req;
      // Under contention the client that was not served last wins.
      if (req == 2'b11) grant = (last == 1'b1) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last <= 1'b1;
      else if (update && (grant != 2'b00)) last <= grant[1];
   end

endmodule

// File: rtl/psram_port_arbiter.sv
// Two-client front end for the PSRAM controller: round-robin grant, one transaction
// in flight, fixed-latency read capture. Client handshake: req is held until a one-cycle ack.
module psram_port_arbiter
   import psram_pkg::*;
#(
   parameter int ADDRESS_BITS = PSRAM_ADDRESS_BITS,
   parameter int DATA_BITS    = PSRAM_DATA_BITS,
   parameter int RD_LATENCY   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    c0_req,
   input  logic                    c0_we,
   input  logic [ADDRESS_BITS-1:0] c0_address,
   input  logic [DATA_BITS-1:0]    c0_wr_data,
   output logic                    c0_ack,
   output logic [DATA_BITS-1:0]    c0_rd_data,
   output logic                    c0_rd_valid,
   input  logic                    c1_req,
   input  logic                    c1_we,
   input  logic [ADDRESS_BITS-1:0] c1_address,
   input  logic [DATA_BITS-1:0]    c1_wr_data,
   output logic                    c1_ack,
   output logic [DATA_BITS-1:0]    c1_rd_data,
   output logic                    c1_rd_valid,
   output logic                    psram_rd_en,
   output logic [ADDRESS_BITS-1:0] psram_rd_address,
   input  logic                    psram_rd_ack,
   input  logic [DATA_BITS-1:0]    psram_rd_data,
   output logic                    psram_wr_en,
   output logic [ADDRESS_BITS-1:0] psram_wr_address,
   output logic [DATA_BITS-1:0]    psram_wr_data,
   input  logic                    psram_wr_ack,
   output arb_state_t              dbg_state
);

   localparam int CNT_W = $clog2(RD_LATENCY + 1);

   arb_state_t              state;
   client_id_t              owner;
   logic [CNT_W-1:0]        cnt;
   logic [1:0]              grant;
   logic                    grant_en;
   client_id_t              sel_id;
   logic                    sel_we;
   logic [ADDRESS_BITS-1:0] sel_address;
   logic [DATA_BITS-1:0]    sel_wr_data;

   psram_rr_arbiter u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    ({c1_req, c0_req}),
      .update (grant_en),
      .grant  (grant)
   );

   // Ack is combinational so a client is accepted in its first requesting IDLE cycle;
   // gating with reset keeps every output low while reset is held.
   assign grant_en    = (state == IDLE) && !reset && (c0_req || c1_req);
   assign c0_ack      = grant_en && grant[0];
   assign c1_ack      = grant_en && grant[1];
   assign sel_id      = grant[1];
   assign sel_we      = sel_id ? c1_we      : c0_we;
   assign sel_address = sel_id ? c1_address : c0_address;
   assign sel_wr_data = sel_id ? c1_wr_data : c0_wr_data;
   assign dbg_state   = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= 1'b0;
         cnt              <= '0;
         psram_rd_en      <= 1'b0;
         psram_wr_en      <= 1'b0;
         psram_rd_address <= '0;
         psram_wr_address <= '0;
         psram_wr_data    <= '0;
         c0_rd_data       <= '0;
         c1_rd_data       <= '0;
         c0_rd_valid      <= 1'b0;
         c1_rd_valid      <= 1'b0;
      end else begin
         c0_rd_valid <= 1'b0;
         c1_rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_en) begin
                  owner            <= sel_id;
                  psram_wr_en      <= sel_we;
                  psram_rd_en      <= !sel_we;
                  psram_rd_address <= sel_address;
                  psram_wr_address <= sel_address;
                  psram_wr_data    <= sel_wr_data;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               // Only the ack of the channel actually enabled is honoured.
               if (psram_wr_en && psram_wr_ack) begin
                  psram_wr_en <= 1'b0;
                  state       <= IDLE;
               end else if (psram_rd_en && psram_rd_ack) begin
                  psram_rd_en <= 1'b0;
                  cnt         <= '0;
                  state       <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (cnt == CNT_W'(RD_LATENCY - 1)) begin
                  if (owner) begin
                     c1_rd_data  <= psram_rd_data;
                     c1_rd_valid <= 1'b1;
                  end else begin
                     c0_rd_data  <= psram_rd_data;
                     c0_rd_valid <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: directed client traffic against a small controller model.
module tb_psram_port_arbiter;
   import psram_pkg::*;

   localparam int AW = 23;
   localparam int DW = 16;
   localparam int RD_LATENCY = 4;

   logic clk, reset;
   logic c0_req, c0_we, c0_ack, c0_rd_valid;
   logic c1_req, c1_we, c1_ack, c1_rd_valid;
   logic [AW-1:0] c0_address, c1_address, psram_rd_address, psram_wr_address;
   logic [DW-1:0] c0_wr_data, c1_wr_data, c0_rd_data, c1_rd_data;
   logic [DW-1:0] psram_rd_data, psram_wr_data;
   logic psram_rd_en, psram_rd_ack, psram_wr_en, psram_wr_ack;
   arb_state_t dbg_state;

   psram_port_arbiter #(.ADDRESS_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(RD_LATENCY)) dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_we(c0_we), .c0_address(c0_address), .c0_wr_data(c0_wr_data),
      .c0_ack(c0_ack), .c0_rd_data(c0_rd_data), .c0_rd_valid(c0_rd_valid),
      .c1_req(c1_req), .c1_we(c1_we), .c1_address(c1_address), .c1_wr_data(c1_wr_data),
      .c1_ack(c1_ack), .c1_rd_data(c1_rd_data), .c1_rd_valid(c1_rd_valid),
      .psram_rd_en(psram_rd_en), .psram_rd_address(psram_rd_address),
      .psram_rd_ack(psram_rd_ack), .psram_rd_data(psram_rd_data),
      .psram_wr_en(psram_wr_en), .psram_wr_address(psram_wr_address),
      .psram_wr_data(psram_wr_data), .psram_wr_ack(psram_wr_ack),
      .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_seen = 0;
   int wr_delay = 0;
   int rd_delay = 0;
   bit stray_wr_ack = 0;
   int last_ack_cyc [2];
   int last_valid_cyc [2];

   logic [DW:0]      exp_q[$];      // {client, read data}
   int               exp_cyc_q[$];  // cycle in which rd_valid must be seen
   logic [AW+DW-1:0] wr_exp_q[$];   // {address, data} of each write issued
   logic             grant_q[$];    // expected grant order under contention
   logic [DW-1:0]    mem [logic [AW-1:0]];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- controller model ----------------
   initial begin
      int wr_wait, rd_wait, rd_phase;
      logic [DW-1:0] rd_val;
      wr_wait = 0; rd_wait = 0; rd_phase = 0; rd_val = '0;
      psram_wr_ack = 1'b0; psram_rd_ack = 1'b0; psram_rd_data = '0;
      forever begin
         @(negedge clk);
         psram_wr_ack = 1'b0;
         psram_rd_ack = 1'b0;
         if (reset) begin
            wr_wait = 0; rd_wait = 0; rd_phase = 0;
            exp_cyc_q.delete();
         end else begin
            // Data is garbage until just after edge E(RD_LATENCY-1), valid from then on.
            if (rd_phase != 0) begin
               if (rd_phase == 1) psram_rd_data = 16'hDEAD;
               if (rd_phase == RD_LATENCY) begin
                  psram_rd_data = rd_val;
                  rd_phase = 0;
               end else rd_phase++;
            end
            if (psram_wr_en) begin
               if (wr_wait >= wr_delay) begin psram_wr_ack = 1'b1; wr_wait = 0; end
               else wr_wait++;
            end else wr_wait = 0;
            if (psram_rd_en) begin
               if (stray_wr_ack) psram_wr_ack = 1'b1;
               if (rd_wait >= rd_delay) begin
                  psram_rd_ack = 1'b1;
                  rd_wait = 0;
                  rd_val = mem.exists(psram_rd_address) ? mem[psram_rd_address] : '0;
                  rd_phase = 1;
                  exp_cyc_q.push_back(cyc + 1 + RD_LATENCY);
               end else rd_wait++;
            end else rd_wait = 0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic prev_wr_en;
      logic [DW:0] got, exp;
      logic [AW+DW-1:0] wgot, wexp;
      logic gexp;
      int ecyc;
      prev_wr_en = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_wr_en = 1'b0;
            continue;
         end
         if (psram_rd_en && psram_wr_en) begin
            checks++; errors++;
            $display("FAIL enables_exclusive: rd_en=1 wr_en=1 at cycle %0d, required at most one", cyc);
         end
         if (psram_wr_en && !prev_wr_en) begin
            checks++;
            wgot = {psram_wr_address, psram_wr_data};
            if (wr_exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got %h, no write expected", wgot);
            end else begin
               wexp = wr_exp_q.pop_front();
               if (wgot !== wexp) begin
                  errors++;
                  $display("FAIL wr_issue: got addr/data %h, expected %h", wgot, wexp);
               end
            end
         end
         prev_wr_en = psram_wr_en;
         if (c0_ack || c1_ack) begin
            if (c0_ack && c1_ack) begin
               checks++; errors++;
               $display("FAIL ack_onehot: c0_ack=1 c1_ack=1, required one-hot");
            end
            last_ack_cyc[c1_ack ? 1 : 0] = cyc;
            if (grant_q.size() != 0) begin
               checks++;
               gexp = grant_q.pop_front();
               if (c1_ack !== gexp) begin
                  errors++;
                  $display("FAIL grant_order: granted c%0d, expected c%0d", c1_ack, gexp);
               end
            end
         end
         if (c0_rd_valid || c1_rd_valid) begin
            valid_seen++;
            last_valid_cyc[c1_rd_valid ? 1 : 0] = cyc;
            checks++;
            got = {c1_rd_valid, c1_rd_valid ? c1_rd_data : c0_rd_data};
            if (c0_rd_valid && c1_rd_valid) begin
               errors++;
               $display("FAIL rd_valid_onehot: both valid, required one");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected: got client/data %h, none expected", got);
            end else begin
               exp = exp_q.pop_front();
               ecyc = (exp_cyc_q.size() != 0) ? exp_cyc_q.pop_front() : -1;
               if (got !== exp || cyc != ecyc) begin
                  errors++;
                  $display("FAIL rd_result: got client/data %h at cycle %0d, expected %h at cycle %0d",
                           got, cyc, exp, ecyc);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int c, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (c == 0) begin c0_req = req; c0_we = we; c0_address = addr; c0_wr_data = wdata; end
      else        begin c1_req = req; c1_we = we; c1_address = addr; c1_wr_data = wdata; end
   endtask

   function automatic logic ack_of(input int c);
      return (c == 0) ? c0_ack : c1_ack;
   endfunction

   task automatic do_req(input int c, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input bit push_rd);
      bit got;
      got = 0;
      @(posedge clk); #1;
      set_req(c, 1'b1, we, addr, wdata);
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (ack_of(c)) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL ack_timeout: c%0d ack=0 after 300 cycles, required 1", c);
         set_req(c, 1'b0, we, addr, wdata);
      end else begin
         if (we) wr_exp_q.push_back({addr, wdata});
         else if (push_rd) exp_q.push_back({c[0], exp_rd});
         @(posedge clk); #1;
         set_req(c, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         checks++;
         if (we ? (psram_wr_en !== 1'b1) : (psram_rd_en !== 1'b1 || psram_rd_address !== addr)) begin
            errors++;
            $display("FAIL enable_after_ack: c%0d wr_en=%b rd_en=%b rd_addr=%h, required %s en with addr %h",
                     c, psram_wr_en, psram_rd_en, psram_rd_address, we ? "wr" : "rd", addr);
         end
      end
   endtask

   task automatic wait_state(input arb_state_t s, input string name);
      bit hit;
      hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         if (dbg_state == s) hit = 1;
      end
      if (!hit) begin
         checks++; errors++;
         $display("FAIL %s: state %0d never reached, stuck in %0d", name, s, dbg_state);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [99:0] outs;
      outs = {c0_ack, c1_ack, c0_rd_data, c1_rd_data, c0_rd_valid, c1_rd_valid, psram_rd_en,
              psram_rd_address, psram_wr_en, psram_wr_address, psram_wr_data};
      checks++;
      if (outs !== '0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL %s: outputs %h state %0d, required all zero and IDLE", name, outs, dbg_state);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int vs;
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      mem[23'h400020] = 16'hBEEF;
      mem[23'h000300] = 16'h5A5A;
      mem[23'h000301] = 16'hC3C3;
      mem[23'h000302] = 16'h7777;
      mem[23'h000303] = 16'h0F0F;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;

      // Contention: grants alternate 0,1,0,1 starting with c0.
      grant_q.push_back(1'b0); grant_q.push_back(1'b1);
      grant_q.push_back(1'b0); grant_q.push_back(1'b1);
      fork
         do_req(0, 1'b1, 23'h000100, 16'h1111, '0, 0);
         do_req(1, 1'b1, 23'h000200, 16'h2222, '0, 0);
      join
      fork
         do_req(0, 1'b1, 23'h000101, 16'h3333, '0, 0);
         do_req(1, 1'b1, 23'h000201, 16'h4444, '0, 0);
      join
      wait_state(IDLE, "contention_idle");

      // Single write, then single read with a stray wr_ack during the read.
      do_req(0, 1'b1, 23'h000010, 16'h1234, '0, 0);
      wait_state(IDLE, "write_idle");
      stray_wr_ack = 1;
      do_req(1, 1'b0, 23'h400020, '0, 16'hBEEF, 1);
      wait_state(IDLE, "read_idle");
      stray_wr_ack = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (c1_rd_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL c1_rd_data_hold: got %h, required beef", c1_rd_data);
      end

      // Request while busy: c0 is accepted in the cycle c1's rd_valid is presented.
      fork
         do_req(1, 1'b0, 23'h000300, '0, 16'h5A5A, 1);
         begin
            wait_state(RD_WAIT, "busy_rd_wait");
            do_req(0, 1'b0, 23'h000301, '0, 16'hC3C3, 1);
         end
      join
      wait_state(IDLE, "busy_idle");
      repeat (RD_LATENCY + 3) @(negedge clk);
      checks++;
      if (last_ack_cyc[0] != last_valid_cyc[1]) begin
         errors++;
         $display("FAIL busy_accept: c0_ack cycle %0d, required c1_rd_valid cycle %0d",
                  last_ack_cyc[0], last_valid_cyc[1]);
      end

      // Slow controller: write held stable while waiting for wr_ack.
      wr_delay = 5;
      fork
         do_req(1, 1'b1, 23'h7FFFFF, 16'hFFFF, '0, 0);
         begin
            wait_state(ISSUE, "slow_issue");
            for (int k = 0; k < 5; k++) begin
               checks++;
               if (psram_wr_en !== 1'b1 || psram_rd_en !== 1'b0 ||
                   psram_wr_address !== 23'h7FFFFF || psram_wr_data !== 16'hFFFF) begin
                  errors++;
                  $display("FAIL slow_hold[%0d]: wr_en=%b rd_en=%b addr=%h data=%h, required 1 0 7fffff ffff",
                           k, psram_wr_en, psram_rd_en, psram_wr_address, psram_wr_data);
               end
               @(negedge clk);
            end
         end
      join
      wait_state(IDLE, "slow_idle");
      wr_delay = 0;

      // Reset mid-read drops the result.
      do_req(1, 1'b0, 23'h000302, '0, '0, 0);
      wait_state(RD_WAIT, "reset_rd_wait");
      #2 reset = 1'b1;
      #1 check_all_zero("reset_midread");
      vs = valid_seen;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (RD_LATENCY + 6) @(negedge clk);
      checks++;
      if (valid_seen != vs) begin
         errors++;
         $display("FAIL reset_drop: %0d rd_valid pulses after reset, required 0", valid_seen - vs);
      end

      // Next request after reset is served normally.
      do_req(0, 1'b0, 23'h000303, '0, 16'h0F0F, 1);
      wait_state(IDLE, "post_reset_idle");
      repeat (RD_LATENCY + 4) @(negedge clk);

      checks++;
      if (exp_q.size() != 0 || wr_exp_q.size() != 0 || grant_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending rd=%0d wr=%0d grant=%0d, required 0 0 0",
                  exp_q.size(), wr_exp_q.size(), grant_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: bench did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
